// File: rtl/kaiser_pkg.sv
// Shared definitions for the writeback stage: control-word and inst_type
// field positions, the squash-counter width and the writeback FSM encoding.
package kaiser_pkg;

    localparam int CTL_W      = 22;
    localparam int IT_W       = 6;
    localparam int CTL_RD_LSB = 0;
    localparam int CTL_RD_W   = 4;
    localparam int CTL_RWE    = 4;
    localparam int CTL_LOADS  = 8;
    localparam int IT_LDR     = 0;
    localparam int IT_STR     = 1;
    localparam int CTR_W      = 3;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_REDIRECT = 2'd1,
        WB_SQUASH   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_squash_ctr.sv
// Loadable down-counter with zero flag. It times the squash window after a
// redirect. It saturates at zero so that a stray decrement cannot wrap.
module wb_squash_ctr
    import kaiser_pkg::*;
#(
    parameter int W = CTR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load has priority over decrement. Decrement stops at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipeline_4_writeback.sv
// Final pipeline stage. It registers the memory-stage outputs, selects the
// register-file write data (ALU result or synchronous-RAM load data) and holds
// the architectural NZV flags. A taken delayed branch redirects the PC and
// kills the wrong-path writebacks for SQUASH_DEPTH cycles.
// Optional feature: define WB_FWD_EN to add the fwd_valid/fwd_addr/fwd_data
// outputs. These outputs give the decode stage a one-cycle-delayed copy of the
// write port.
// Handshake: there is no valid/ready. Every input is sampled on every rising
// edge, and pc_load is a single-cycle strobe that the fetch stage must act on.
module pipeline_4_writeback
    import kaiser_pkg::*;
#(
    parameter int SQUASH_DEPTH = 2,
    parameter int DW           = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CTL_W-1:0]    control_in,
    input  logic [IT_W-1:0]     inst_type_in,
    input  logic [DW-1:0]       result_in,
    input  logic [DW-1:0]       rdata_mem,
    input  logic                N_in,
    input  logic                V_in,
    input  logic                Z_in,
    input  logic                do_delayed_B,
    input  logic [DW-1:0]       delayed_B_in,
    output logic                rf_we,
    output logic [CTL_RD_W-1:0] rf_waddr,
    output logic [DW-1:0]       rf_wdata,
    output logic                N_q,
    output logic                V_q,
    output logic                Z_q,
    output logic                pc_load,
    output logic [DW-1:0]       pc_target,
    output logic                squash,
    output wb_state_t           state_dbg
`ifdef WB_FWD_EN
    ,
    output logic                fwd_valid,
    output logic [CTL_RD_W-1:0] fwd_addr,
    output logic [DW-1:0]       fwd_data
`endif
);

    wb_state_t           state;
    logic [CTL_RD_W-1:0] rd_q;
    logic                rwe_q;
    logic                ldr_q;
    logic                str_q;
    logic [DW-1:0]       result_q;
    logic [CTR_W-1:0]    ctr_count;
    logic                ctr_zero;
    logic                unused_bits;

    // The control word carries fields for earlier stages that this stage ignores.
    assign unused_bits = ^{control_in[CTL_W-1:CTL_LOADS+1],
                           control_in[CTL_LOADS-1:CTL_RWE+1],
                           inst_type_in[IT_W-1:IT_STR+1]};

    // Stage register: capture the fields this stage consumes on every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q     <= '0;
            rwe_q    <= 1'b0;
            ldr_q    <= 1'b0;
            str_q    <= 1'b0;
            result_q <= '0;
        end else begin
            rd_q     <= control_in[CTL_RD_LSB +: CTL_RD_W];
            rwe_q    <= control_in[CTL_RWE];
            ldr_q    <= inst_type_in[IT_LDR];
            str_q    <= inst_type_in[IT_STR];
            result_q <= result_in;
        end
    end

    // The RAM returns load data in the cycle the LDR sits in this stage.
    // A store never writes a register, and a write is killed while squashing.
    assign rf_waddr = rd_q;
    assign rf_wdata = ldr_q ? rdata_mem : result_q;
    assign rf_we    = rwe_q & ~str_q & ~squash & (state != WB_REDIRECT);

    // Architectural flags: load only when asked, and never on the wrong path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            N_q <= 1'b0;
            V_q <= 1'b0;
            Z_q <= 1'b0;
        end else if (control_in[CTL_LOADS] && !squash) begin
            N_q <= N_in;
            V_q <= V_in;
            Z_q <= Z_in;
        end
    end

    // Redirect FSM. The REDIRECT cycle counts as the first squash cycle.
    // SQUASH then covers the remaining SQUASH_DEPTH-1 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= WB_IDLE;
            pc_load   <= 1'b0;
            squash    <= 1'b0;
            pc_target <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (do_delayed_B) begin
                        state     <= WB_REDIRECT;
                        pc_load   <= 1'b1;
                        squash    <= 1'b1;
                        pc_target <= delayed_B_in;
                    end else begin
                        pc_load <= 1'b0;
                        squash  <= 1'b0;
                    end
                end
                WB_REDIRECT: begin
                    pc_load <= 1'b0;
                    if (SQUASH_DEPTH == 1) begin
                        state  <= WB_IDLE;
                        squash <= 1'b0;
                    end else begin
                        state  <= WB_SQUASH;
                        squash <= 1'b1;
                    end
                end
                WB_SQUASH: begin
                    pc_load <= 1'b0;
                    if (ctr_zero || (ctr_count == CTR_W'(1))) begin
                        state  <= WB_IDLE;
                        squash <= 1'b0;
                    end
                end
                default: begin
                    state   <= WB_IDLE;
                    pc_load <= 1'b0;
                    squash  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

    wb_squash_ctr #(.W(CTR_W)) u_squash_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (state == WB_REDIRECT),
        .load_val (CTR_W'(SQUASH_DEPTH - 1)),
        .dec      (state == WB_SQUASH),
        .count    (ctr_count),
        .zero     (ctr_zero)
    );

`ifdef WB_FWD_EN
    // Copy of the write port one cycle late, used for the decode-stage bypass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= rf_we;
            fwd_addr  <= rf_waddr;
            fwd_data  <= rf_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_4_writeback.sv
// Directed bench for pipeline_4_writeback (SQUASH_DEPTH=2, DW=16).
module tb_pipeline_4_writeback;
    import kaiser_pkg::*;

    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CTL_W-1:0] control_in = '0;
    logic [IT_W-1:0]  inst_type_in = '0;
    logic [DW-1:0]    result_in = '0;
    logic [DW-1:0]    rdata_mem = '0;
    logic             N_in = 1'b0, V_in = 1'b0, Z_in = 1'b0;
    logic             do_delayed_B = 1'b0;
    logic [DW-1:0]    delayed_B_in = '0;
    logic             rf_we;
    logic [3:0]       rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic             N_q, V_q, Z_q;
    logic             pc_load;
    logic [DW-1:0]    pc_target;
    logic             squash;
    wb_state_t        state_dbg;
`ifdef WB_FWD_EN
    logic             fwd_valid;
    logic [3:0]       fwd_addr;
    logic [DW-1:0]    fwd_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_4_writeback #(.SQUASH_DEPTH(2), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .control_in(control_in), .inst_type_in(inst_type_in),
        .result_in(result_in), .rdata_mem(rdata_mem),
        .N_in(N_in), .V_in(V_in), .Z_in(Z_in),
        .do_delayed_B(do_delayed_B), .delayed_B_in(delayed_B_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .N_q(N_q), .V_q(V_q), .Z_q(Z_q),
        .pc_load(pc_load), .pc_target(pc_target), .squash(squash),
        .state_dbg(state_dbg)
`ifdef WB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    function automatic logic [CTL_W-1:0] ctl(input logic we, input logic ldf, input logic [3:0] rd);
        logic [CTL_W-1:0] c;
        c = '0;
        c[CTL_RD_LSB +: 4] = rd;
        c[CTL_RWE]         = we;
        c[CTL_LOADS]       = ldf;
        return c;
    endfunction

    task automatic drive(input logic [CTL_W-1:0] c, input logic [IT_W-1:0] it, input logic [DW-1:0] res);
        control_in   = c;
        inst_type_in = it;
        result_in    = res;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_wdata", 32'(rf_wdata), 32'h0);
        check("rst_pc_load", 32'(pc_load), 32'd0);
        check("rst_squash", 32'(squash), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(WB_IDLE));
        @(negedge clk);
        rst = 1'b1;

        // 1: ADD Rd=3
        drive(ctl(1'b1, 1'b0, 4'd3), 6'b000000, 16'h1234);
        step();
        check("add_we", 32'(rf_we), 32'd1);
        check("add_waddr", 32'(rf_waddr), 32'd3);
        check("add_wdata", 32'(rf_wdata), 32'h1234);

        // 2: LDR Rd=5, data arrives the cycle after the address
        drive(ctl(1'b1, 1'b0, 4'd5), 6'b000001, 16'h0100);
        step();
        rdata_mem = 16'hBEEF;
        #1;
        check("ldr_we", 32'(rf_we), 32'd1);
        check("ldr_waddr", 32'(rf_waddr), 32'd5);
        check("ldr_wdata", 32'(rf_wdata), 32'hBEEF);
`ifdef WB_FWD_EN
        check("fwd_valid", 32'(fwd_valid), 32'd1);
        check("fwd_addr", 32'(fwd_addr), 32'd3);
        check("fwd_data", 32'(fwd_data), 32'h1234);
`endif
        drive(ctl(1'b1, 1'b0, 4'd7), 6'b000010, 16'h0200);
        step();
        check("str_we", 32'(rf_we), 32'd0);

        // 3: flags load and hold
        drive(ctl(1'b0, 1'b1, 4'd0), 6'b000000, 16'h0);
        N_in = 1'b1; V_in = 1'b0; Z_in = 1'b0;
        step();
        check("flags_load", 32'({N_q, V_q, Z_q}), 32'b100);
        drive(ctl(1'b0, 1'b0, 4'd0), 6'b000000, 16'h0);
        N_in = 1'b0; V_in = 1'b1; Z_in = 1'b1;
        step();
        check("flags_hold", 32'({N_q, V_q, Z_q}), 32'b100);
        drive(ctl(1'b0, 1'b1, 4'd0), 6'b000000, 16'h0);
        step();
        check("flags_load2", 32'({N_q, V_q, Z_q}), 32'b011);

        // 4: branch to 0x0040, two writes killed, third written
        drive(ctl(1'b1, 1'b0, 4'd1), 6'b000000, 16'h1111);
        do_delayed_B = 1'b1; delayed_B_in = 16'h0040;
        step();
        check("br_pc_load", 32'(pc_load), 32'd1);
        check("br_target", 32'(pc_target), 32'h0040);
        check("br_squash", 32'(squash), 32'd1);
        check("br_we1", 32'(rf_we), 32'd0);
        check("br_state", 32'(state_dbg), 32'(WB_REDIRECT));
        drive(ctl(1'b1, 1'b1, 4'd2), 6'b000000, 16'h2222);
        do_delayed_B = 1'b0;
        N_in = 1'b1; V_in = 1'b0; Z_in = 1'b0;
        step();
        check("sq_pc_load", 32'(pc_load), 32'd0);
        check("sq_squash", 32'(squash), 32'd1);
        check("sq_we2", 32'(rf_we), 32'd0);
        check("sq_state", 32'(state_dbg), 32'(WB_SQUASH));
        check("sq_flags", 32'({N_q, V_q, Z_q}), 32'b011);
        drive(ctl(1'b1, 1'b0, 4'd3), 6'b000000, 16'h3333);
        N_in = 1'b0;
        step();
        check("post_we3", 32'(rf_we), 32'd1);
        check("post_waddr", 32'(rf_waddr), 32'd3);
        check("post_wdata", 32'(rf_wdata), 32'h3333);
        check("post_squash", 32'(squash), 32'd0);
        check("post_state", 32'(state_dbg), 32'(WB_IDLE));

        // 5: branch inside the window ignored, branch at IDLE re-entry accepted
        drive(ctl(1'b0, 1'b0, 4'd0), 6'b000000, 16'h0);
        do_delayed_B = 1'b1; delayed_B_in = 16'h0080;
        step();
        check("b2_pc_load", 32'(pc_load), 32'd1);
        check("b2_target", 32'(pc_target), 32'h0080);
        delayed_B_in = 16'h0099;
        step();
        check("b2_wrong_load", 32'(pc_load), 32'd0);
        check("b2_wrong_tgt", 32'(pc_target), 32'h0080);
        delayed_B_in = 16'h00A0;
        step();
        check("reent_pc_load", 32'(pc_load), 32'd0);
        check("reent_state", 32'(state_dbg), 32'(WB_IDLE));
        step();
        check("b3_pc_load", 32'(pc_load), 32'd1);
        check("b3_target", 32'(pc_target), 32'h00A0);
        do_delayed_B = 1'b0;
        step();
        check("b3_state", 32'(state_dbg), 32'(WB_SQUASH));

        // 6: asynchronous reset in SQUASH
        #2;
        rst = 1'b0;
        #1;
        check("arst_pc_load", 32'(pc_load), 32'd0);
        check("arst_squash", 32'(squash), 32'd0);
        check("arst_target", 32'(pc_target), 32'h0);
        check("arst_flags", 32'({N_q, V_q, Z_q}), 32'b000);
        check("arst_state", 32'(state_dbg), 32'(WB_IDLE));
`ifdef WB_FWD_EN
        check("arst_fwd_valid", 32'(fwd_valid), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rel_pc_load", 32'(pc_load), 32'd0);
            check("rel_state", 32'(state_dbg), 32'(WB_IDLE));
        end

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
